// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-PC redirect controller: FSM states, PC step, default reset PC.
package pc_redirect_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module pc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner and redirect sequencer; a redirect during a busy fetch is parked in a pending slot.
// Optional statistics counters are built when REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             ex_valid,
  input  logic             ex_pc_src,
  input  logic [31:0]      ex_target,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             if_id_hold,
`ifdef REDIRECT_STATS_EN
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             misalign_err
);

  pc_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic        r_misalign;
  logic        w_redir;
  logic [31:0] w_tgt;

  // Redirects arriving while PEND is outstanding come from wrong-path bubbles and are dropped.
  assign w_redir = ex_valid & ex_pc_src & (r_state == ST_RUN) & ~rst;
  assign w_tgt   = word_align(ex_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redir) begin
            if (ex_target[1:0] != 2'b00) r_misalign <= 1'b1;
            if (imem_ready) begin
              r_pc <= w_tgt;
            end else begin
              r_pend  <= w_tgt;
              r_state <= ST_PEND;
            end
          end else if (!stall && imem_ready) begin
            r_pc <= r_pc + PC_INC;
          end
        end
        ST_PEND: begin
          if (imem_ready) begin
            r_pc    <= r_pend;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if_id_hold  = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (r_state == ST_PEND) begin
      if_id_flush = 1'b1;
    end else if (w_redir) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  assign imem_req     = ~rst;
  assign pc           = r_pc;
  assign misalign_err = r_misalign;

`ifdef REDIRECT_STATS_EN
  logic w_stall_evt;
  assign w_stall_evt = stall & ~w_redir & ~rst;

  pc_sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redir),
    .count (redirect_cnt)
  );

  pc_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_evt),
    .count (stall_cnt)
  );
`else
  // Counter width only matters when the statistics are built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed plus randomized bench for pc_redirect_ctrl against a cycle-level reference model.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_pc_src = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] pc;
  logic        imem_req, if_id_flush, id_ex_flush, if_id_hold, misalign_err;
`ifdef REDIRECT_STATS_EN
  logic [1:0]  redirect_cnt, stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  bit          m_known = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_pend_tgt = '0;

  always #5 clk = ~clk;

`ifdef REDIRECT_STATS_EN
  pc_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut (
`else
  pc_redirect_ctrl #(.RESET_PC(32'h0)) dut (
`endif
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .ex_valid     (ex_valid),
    .ex_pc_src    (ex_pc_src),
    .ex_target    (ex_target),
    .pc           (pc),
    .imem_req     (imem_req),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .if_id_hold   (if_id_hold),
`ifdef REDIRECT_STATS_EN
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .misalign_err (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit st, input bit rdy, input bit ev, input bit src,
                      input logic [31:0] t);
    bit take;
    bit e_iff, e_ief, e_hold;
    @(negedge clk);
    rst = r; stall = st; imem_ready = rdy; ex_valid = ev; ex_pc_src = src; ex_target = t;
    #1;
    take   = !r && !m_pend && ev && src;
    e_iff  = r || m_pend || take;
    e_ief  = r || (!m_pend && (take || st));
    e_hold = !r && !m_pend && !take && st;
    chk("imem_req", {31'd0, imem_req}, {31'd0, !r});
    chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_iff});
    chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_ief});
    chk("if_id_hold", {31'd0, if_id_hold}, {31'd0, e_hold});
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
    end
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_pend = 1'b0; m_err = 1'b0; m_known = 1'b1;
    end else if (m_pend) begin
      if (rdy) begin
        m_pc = m_pend_tgt; m_pend = 1'b0;
      end
    end else if (take) begin
      if (t[1:0] != 2'b00) m_err = 1'b1;
      if (rdy) m_pc = t & 32'hFFFF_FFFC;
      else begin
        m_pend = 1'b1; m_pend_tgt = t & 32'hFFFF_FFFC;
      end
    end else if (!st && rdy) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    // Reset and sequential fetch
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    step(0, 0, 1, 0, 0, 0);
    chk("seq_pc_4", pc, 32'h4);
    step(0, 0, 1, 0, 0, 0);
    chk("seq_pc_8", pc, 32'h8);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("seq_pc_10", pc, 32'h10);

    // Taken branch with fetch accepted
    step(0, 0, 1, 1, 1, 32'h40);
    chk("branch_pc_40", pc, 32'h40);

    // Redirect during busy fetch; a second redirect in PEND is ignored
    step(0, 0, 0, 1, 1, 32'h80);
    chk("pend_pc_hold", pc, 32'h40);
    step(0, 0, 0, 1, 1, 32'h300);
    step(0, 0, 1, 0, 0, 0);
    chk("pend_pc_80", pc, 32'h80);

    // Redirect beats stall, then stall alone
    step(0, 1, 1, 1, 1, 32'h200);
    chk("stall_redir_pc", pc, 32'h200);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    chk("stall_pc_const", pc, 32'h200);

    // Misaligned target and wrap-around
    step(0, 0, 1, 1, 1, 32'h102);
    chk("misalign_pc", pc, 32'h100);
    chk("misalign_set", {31'd0, misalign_err}, 32'd1);
    step(0, 0, 1, 1, 1, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset while a redirect is pending drops it
    step(0, 0, 0, 1, 1, 32'h500);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_pend_pc", pc, 32'h0);
    step(0, 0, 1, 0, 0, 0);
    chk("rst_pend_next", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, t);
    end

`ifdef REDIRECT_STATS_EN
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 32'h1000 + 32'(i * 16));
    chk("redirect_cnt_sat", {30'd0, redirect_cnt}, 32'd3);
    step(1, 0, 0, 0, 0, 0);
    chk("redirect_cnt_rst", {30'd0, redirect_cnt}, 32'd0);
    chk("stall_cnt_rst", {30'd0, stall_cnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
